// File: rtl/id_operand_unit_if.sv
// Decode-stage operand bus: immediate extraction signals plus the
// register-file read/write ports. The decoder/writeback side is the master.
interface id_operand_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [31:0]     instr_i;
    logic [2:0]      format_i;
    logic [XLEN-1:0] imm_o;
    logic [4:0]      raddr_a_i;
    logic [4:0]      raddr_b_i;
    logic            wen_i;
    logic [4:0]      waddr_i;
    logic [XLEN-1:0] wdata_i;
    logic [XLEN-1:0] rdata_a_o;
    logic [XLEN-1:0] rdata_b_o;

    modport master (
        output instr_i, format_i, raddr_a_i, raddr_b_i, wen_i, waddr_i, wdata_i,
        input  imm_o, rdata_a_o, rdata_b_o
    );

    modport slave (
        input  instr_i, format_i, raddr_a_i, raddr_b_i, wen_i, waddr_i, wdata_i,
        output imm_o, rdata_a_o, rdata_b_o
    );
endinterface

// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: RV32I immediate generator and a 32-entry
// integer register file with two combinational read ports, one
// synchronous write port and write-first bypass from writeback.
module id_operand_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input logic              clk,
    input logic              rst,
    id_operand_unit_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_NOP = 3'd0,
        FMT_R   = 3'd1,
        FMT_I   = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_JALR = 7'b1100111;

    fmt_e            fmt;
    logic [31:0]     instr;
    logic [31:0]     imm32;
    logic            wr_en;
    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    assign fmt   = fmt_e'(bus.format_i);
    assign instr = bus.instr_i;
    assign wr_en = bus.wen_i && (bus.waddr_i != '0);

    // Immediate extraction; the decoder tags JALR as J, so it is re-decoded as I here
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: begin
                if (instr[6:0] == OPC_JALR)
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                else
                    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: imm32 = '0;
        endcase
        bus.imm_o = XLEN'($signed(imm32));
    end

    // Next register-file contents; entry 0 is pinned to zero
    always_comb begin
        mem_d = mem_q;
        if (wr_en)
            mem_d[bus.waddr_i] = bus.wdata_i;
        mem_d[0] = '0;
    end

    // Register-file storage with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++)
                mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports with independent write-first bypass; zero while in reset
    always_comb begin
        bus.rdata_a_o = '0;
        bus.rdata_b_o = '0;
        if (rst) begin
            if (wr_en && (bus.waddr_i == bus.raddr_a_i))
                bus.rdata_a_o = bus.wdata_i;
            else
                bus.rdata_a_o = mem_q[bus.raddr_a_i];
            if (wr_en && (bus.waddr_i == bus.raddr_b_i))
                bus.rdata_b_o = bus.wdata_i;
            else
                bus.rdata_b_o = mem_q[bus.raddr_b_i];
        end
    end
endmodule

// File: tb/tb_id_operand_unit.sv
// Directed-vector bench for id_operand_unit: immediate formats, reset,
// write/read, x0 protection, bypass and mid-operation reset.
module tb_id_operand_unit;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    id_operand_unit_if #(.XLEN(32)) bus ();

    id_operand_unit #(.XLEN(32), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Step to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.wen_i   = 1'b1;
        bus.waddr_i = a;
        bus.wdata_i = d;
        step();
        bus.wen_i   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            bus.raddr_a_i = 5'(i);
            bus.raddr_b_i = 5'(31 - i);
            #1;
            check($sformatf("%s_a%0d", tag, i), bus.rdata_a_o, 32'h0);
            check($sformatf("%s_b%0d", tag, 31 - i), bus.rdata_b_o, 32'h0);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] exp;
    } imm_vec_t;

    imm_vec_t imm_vecs[10];

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst           = 1'b0;
        bus.instr_i   = '0;
        bus.format_i  = '0;
        bus.raddr_a_i = '0;
        bus.raddr_b_i = '0;
        bus.wen_i     = 1'b0;
        bus.waddr_i   = '0;
        bus.wdata_i   = '0;

        imm_vecs[0] = '{"imm_I",    32'hFFF00093, 3'd2, 32'hFFFFFFFF};
        imm_vecs[1] = '{"imm_S",    32'hFE20AE23, 3'd3, 32'hFFFFFFFC};
        imm_vecs[2] = '{"imm_B",    32'hFE000CE3, 3'd4, 32'hFFFFFFF8};
        imm_vecs[3] = '{"imm_U",    32'h123452B7, 3'd5, 32'h12345000};
        imm_vecs[4] = '{"imm_J",    32'h001000EF, 3'd6, 32'h00000800};
        imm_vecs[5] = '{"imm_R",    32'hFFF00093, 3'd1, 32'h00000000};
        imm_vecs[6] = '{"imm_JALR", 32'h00C08067, 3'd6, 32'h0000000C};
        imm_vecs[7] = '{"imm_NOP",  32'hFFFFFFFF, 3'd0, 32'h00000000};
        imm_vecs[8] = '{"imm_RSV",  32'hFFFFFFFF, 3'd7, 32'h00000000};
        imm_vecs[9] = '{"imm_Ipos", 32'h7FF00013, 3'd2, 32'h000007FF};

        // Reset held: outputs zero, immediate path live
        step();
        step();
        bus.raddr_a_i = 5'd5;
        bus.raddr_b_i = 5'd31;
        #1;
        check("rst_rdata_a", bus.rdata_a_o, 32'h0);
        check("rst_rdata_b", bus.rdata_b_o, 32'h0);
        foreach (imm_vecs[k]) begin
            bus.instr_i  = imm_vecs[k].instr;
            bus.format_i = imm_vecs[k].fmt;
            #1;
            check(imm_vecs[k].tag, bus.imm_o, imm_vecs[k].exp);
        end

        // Release reset between edges, then all entries read zero
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("post_rst");

        // Basic write/read on both ports
        @(negedge clk);
        write_reg(5'd5, 32'hDEADBEEF);
        bus.raddr_a_i = 5'd5;
        bus.raddr_b_i = 5'd5;
        #1;
        check("x5_a", bus.rdata_a_o, 32'hDEADBEEF);
        check("x5_b", bus.rdata_b_o, 32'hDEADBEEF);

        // x0 protection, same cycle and later
        @(negedge clk);
        bus.wen_i     = 1'b1;
        bus.waddr_i   = 5'd0;
        bus.wdata_i   = 32'h12345678;
        bus.raddr_a_i = 5'd0;
        bus.raddr_b_i = 5'd0;
        #1;
        check("x0_same_a", bus.rdata_a_o, 32'h0);
        check("x0_same_b", bus.rdata_b_o, 32'h0);
        step();
        bus.wen_i = 1'b0;
        #1;
        check("x0_later_a", bus.rdata_a_o, 32'h0);
        check("x0_later_b", bus.rdata_b_o, 32'h0);

        // Bypass on port A only, then on both ports
        @(negedge clk);
        write_reg(5'd7, 32'h11111111);
        write_reg(5'd3, 32'h33333333);
        @(negedge clk);
        bus.raddr_a_i = 5'd7;
        bus.raddr_b_i = 5'd3;
        #1;
        check("x7_before", bus.rdata_a_o, 32'h11111111);
        bus.wen_i   = 1'b1;
        bus.waddr_i = 5'd7;
        bus.wdata_i = 32'h22222222;
        #1;
        check("byp_a", bus.rdata_a_o, 32'h22222222);
        check("byp_b_nobyp", bus.rdata_b_o, 32'h33333333);
        bus.raddr_b_i = 5'd7;
        #1;
        check("byp_b", bus.rdata_b_o, 32'h22222222);
        step();
        bus.wen_i = 1'b0;
        #1;
        check("byp_next_a", bus.rdata_a_o, 32'h22222222);

        // Fill x1..x31 with nonzero values and spot-check
        @(negedge clk);
        for (int i = 1; i < 32; i++)
            write_reg(5'(i), 32'h01010101 * i + 32'h5);
        bus.raddr_a_i = 5'd1;
        bus.raddr_b_i = 5'd31;
        #1;
        check("fill_x1", bus.rdata_a_o, 32'h0101010A - 32'h0 - 32'h0 + 32'h0 - 32'h4);
        check("fill_x31", bus.rdata_b_o, 32'h1F1F1F24);

        // Mid-cycle reset: contents clear immediately
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_a", bus.rdata_a_o, 32'h0);
        check("mid_rst_b", bus.rdata_b_o, 32'h0);

        // Write attempted during reset is dropped and not bypassed
        bus.wen_i     = 1'b1;
        bus.waddr_i   = 5'd9;
        bus.wdata_i   = 32'hCAFEF00D;
        bus.raddr_a_i = 5'd9;
        #1;
        check("rst_no_byp", bus.rdata_a_o, 32'h0);
        step();
        step();
        @(negedge clk);
        bus.wen_i = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_write_dropped", bus.rdata_a_o, 32'h0);
        check_all_zero("mid_rst_rel");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/id_operand_unit.md
Name: id_operand_unit

Overview:
- Decode-stage operand block with two parts.
- Immediate extraction: builds the sign-extended immediate from a 32-bit RV32I instruction and a decoder-supplied format code.
- Register file: 32x32 integer register file with two combinational read ports (rs1, rs2) and one synchronous write port driven by writeback.
- Sits inside the decoder, between instruction fetch and the ID/EX pipeline register.

Parameters:
- XLEN, 32, data width of registers and immediate.
- NREGS, 32, number of architectural registers; address width is 5.

Ports:
- clk  in  1  core clock; all register writes occur on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- instr_i  in  32  raw instruction word.
- format_i  in  3  instruction format code: NOP=0, R=1, I=2, S=3, B=4, U=5, J=6; 7 is reserved.
- imm_o  out  32  sign-extended immediate (combinational).
- raddr_a_i  in  5  read address, port A (rs1).
- raddr_b_i  in  5  read address, port B (rs2).
- wen_i  in  1  write enable from writeback.
- waddr_i  in  5  write address (rd).
- wdata_i  in  32  write data.
- rdata_a_o  out  32  read data, port A (combinational).
- rdata_b_o  out  32  read data, port B (combinational).

Behaviour:
- Immediate path is purely combinational, zero latency, and independent of clk/rst.
- Immediate by format_i:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - J with instr[6:0]=7'b1100111 (JALR): treat as I (sext(instr[31:20])). The decoder tags JALR as J.
  - R, NOP and reserved code 7: imm_o = 0.
- Sign extension always replicates instr[31].
- Shift-immediates get no special casing: imm_o carries instr[31:20] sign-extended; the ALU uses the low 5 bits.
- Register file storage: 32 entries x XLEN. Entry 0 reads as 0 at all times and is never written.
- Reset: while rst=0, all 31 writable entries are asynchronously cleared to 0. A write presented during reset is discarded. Reset may assert mid-operation; contents clear immediately, without waiting for a clock edge.
- Write: on posedge clk with rst=1, wen_i=1 and waddr_i!=0, mem[waddr_i] <= wdata_i.
  - wen_i=1 with waddr_i=0 has no effect.
  - wen_i=0 leaves contents unchanged.
- Read: rdata_x_o = mem[raddr_x_i], combinational.
  - raddr=0 always returns 0.
  - Both ports may address the same register and both return the same value.
- Write-first bypass: when rst=1, wen_i=1, waddr_i!=0 and waddr_i==raddr_x_i in the same cycle, rdata_x_o = wdata_i. This removes the WB->ID hazard.
  - Bypass applies independently to each port.
  - No bypass when waddr_i=0 or when in reset.
- Outputs during reset: rdata_a_o = rdata_b_o = 0. imm_o still follows instr_i/format_i.
- No X propagation: every output is defined for all input values, including reserved format codes.

Test Plan:
- Immediate formats, one per case:
  - I: instr 0xFFF00093, format 2 -> imm_o 0xFFFFFFFF.
  - S: 0xFE20AE23, format 3 -> 0xFFFFFFFC.
  - B: 0xFE000CE3, format 4 -> 0xFFFFFFF8.
  - U: 0x123452B7, format 5 -> 0x12345000.
  - J: 0x001000EF, format 6 -> 0x00000800.
  - R: format 1 with any instr -> 0.
- JALR special case: instr 0x00C08067 (jalr x0,12(x1)), format 6 -> imm_o 0x0000000C, not the J-decode of the bits.
- Reset and basic write/read:
  - Hold rst=0, then release; read all 32 addresses on both ports -> all 0.
  - Write x5=0xDEADBEEF; next cycle raddr_a=5 -> 0xDEADBEEF and raddr_b=5 -> 0xDEADBEEF.
- x0 protection: wen=1, waddr=0, wdata=0x12345678 -> reading addr 0 returns 0 both in the same cycle and in later cycles.
- Bypass:
  - x7 holds 0x11111111. Same cycle: wen=1, waddr=7, wdata=0x22222222, raddr_a=7, raddr_b=3 -> rdata_a=0x22222222, rdata_b=mem[3].
  - Next cycle: rdata_a=0x22222222.
- Mid-operation reset:
  - With x1..x31 written nonzero, assert rst=0 between clock edges -> reads return 0 immediately.
  - Writes attempted during reset are dropped.
  - After release, all entries read 0.
